reg_op_sequencer: RTL and testbench

Multi-cycle execute/writeback controller that sits directly upstream of the 16-bit register file. It accepts one 16-bit instruction at a time over a valid/ready handshake and drives the register file's two read addresses. It captures both read operands, computes a 16-bit ALU result and condition flags, then writes the result back through the file's address-1 write port. It is the producer of every `register1`/`register2`/`data_in`/`write` value the register file sees.

---
 rtl/reg_op_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reg_op_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// Four-state execute/writeback sequencer feeding a two-read/one-write register file.
// Each instruction walks IDLE -> READ -> EXEC -> WRITE regardless of opcode or legality.
module reg_op_sequencer #(
    parameter int WIDTH   = 16,
    parameter int MAX_REG = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      inst,
    input  logic             inst_valid,
    output logic             inst_ready,
    output logic [4:0]       reg_addr1,
    output logic [4:0]       reg_addr2,
    input  logic [WIDTH-1:0] reg_r1_data,
    input  logic [WIDTH-1:0] reg_r2_data,
    output logic [WIDTH-1:0] reg_wdata,
    output logic             reg_write,
    output logic             done,
    output logic             err,
    output logic [3:0]       flags
);

    // Handshake: an instruction transfers on a rising edge where inst_valid && inst_ready;
    // inst_valid seen while inst_ready is low is dropped, never queued.

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_MOVI = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t            state;
    logic [15:0]       inst_q;
    logic              legal_q;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;

    logic [3:0]        opc;
    logic [WIDTH-1:0]  imm_sx;
    logic [WIDTH-1:0]  add_b;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    dif_ext;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;
    logic              alu_f;
    logic              sets_flags;
    logic              inst_legal;

    function automatic logic reg_ok(input logic [3:0] r);
        reg_ok = (r != 4'd0) && (int'(r) <= MAX_REG);
    endfunction

    always_comb begin
        case (inst[15:12])
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_MOV, OP_CMP:  inst_legal = reg_ok(inst[11:8]) && reg_ok(inst[3:0]);
            OP_MOVI, OP_ADDI:        inst_legal = reg_ok(inst[11:8]);
            default:                 inst_legal = 1'b0;
        endcase
    end

    assign opc     = inst_q[15:12];
    assign imm_sx  = {{(WIDTH-8){inst_q[7]}}, inst_q[7:0]};
    assign add_b   = (opc == OP_ADDI) ? imm_sx : op_b;
    assign sum_ext = {1'b0, op_a} + {1'b0, add_b};
    // The extra MSB of the widened difference is exactly the unsigned borrow (A < B).
    assign dif_ext = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        alu_res    = '0;
        alu_c      = 1'b0;
        alu_f      = 1'b0;
        sets_flags = 1'b0;
        case (opc)
            OP_ADD, OP_ADDI: begin
                alu_res    = sum_ext[WIDTH-1:0];
                alu_c      = sum_ext[WIDTH];
                alu_f      = (op_a[WIDTH-1] == add_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
                sets_flags = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_res    = dif_ext[WIDTH-1:0];
                alu_c      = dif_ext[WIDTH];
                alu_f      = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
                sets_flags = 1'b1;
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_MOV:  alu_res = op_b;
            OP_MOVI: alu_res = {{(WIDTH-8){1'b0}}, inst_q[7:0]};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            inst_ready <= 1'b0;
            inst_q     <= '0;
            legal_q    <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            reg_addr1  <= '0;
            reg_addr2  <= '0;
            reg_wdata  <= '0;
            reg_write  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            flags      <= 4'b0000;
        end else begin
            reg_addr1 <= '0;
            reg_addr2 <= '0;
            reg_wdata <= '0;
            reg_write <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    inst_ready <= 1'b1;
                    if (inst_valid && inst_ready) begin
                        inst_q     <= inst;
                        legal_q    <= inst_legal;
                        inst_ready <= 1'b0;
                        reg_addr1  <= {1'b0, inst[11:8]};
                        reg_addr2  <= {1'b0, inst[3:0]};
                        state      <= READ;
                    end
                end
                READ: begin
                    op_a  <= reg_r1_data;
                    op_b  <= reg_r2_data;
                    state <= EXEC;
                end
                EXEC: begin
                    if (legal_q && sets_flags)
                        flags <= {alu_f, alu_res[WIDTH-1], alu_c, (alu_res == '0)};
                    reg_addr1 <= {1'b0, inst_q[11:8]};
                    reg_wdata <= alu_res;
                    reg_write <= legal_q && (opc != OP_CMP);
                    done      <= 1'b1;
                    err       <= ~legal_q;
                    state     <= WRITE;
                end
                WRITE: begin
                    inst_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: a behavioural register file, a directed vector table,
// and hand-written reset-mid-operation and continuous-valid handshake sequences.
module tb_reg_op_sequencer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      inst;
    logic             inst_valid;
    logic             inst_ready;
    logic [4:0]       reg_addr1;
    logic [4:0]       reg_addr2;
    logic [WIDTH-1:0] reg_r1_data;
    logic [WIDTH-1:0] reg_r2_data;
    logic [WIDTH-1:0] reg_wdata;
    logic             reg_write;
    logic             done;
    logic             err;
    logic [3:0]       flags;

    logic [15:0] rf [32];
    logic        rf_clr;
    logic        poke_en;
    logic [4:0]  poke_addr;
    logic [15:0] poke_data;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;

    typedef struct {
        logic [15:0] inst;
        logic [4:0]  addr1;
        logic [15:0] wdata;
        logic        chk_wdata;
        logic        write;
        logic        err;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs [16];

    reg_op_sequencer #(.WIDTH(WIDTH), .MAX_REG(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .reg_addr1   (reg_addr1),
        .reg_addr2   (reg_addr2),
        .reg_r1_data (reg_r1_data),
        .reg_r2_data (reg_r2_data),
        .reg_wdata   (reg_wdata),
        .reg_write   (reg_write),
        .done        (done),
        .err         (err),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    // Register file model: combinational reads, write on the rising edge.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (poke_en) begin
            rf[poke_addr] <= poke_data;
        end else if (reg_write) begin
            rf[reg_addr1] <= reg_wdata;
        end
        if (reg_write) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    assign reg_r1_data = rf[reg_addr1];
    assign reg_r2_data = rf[reg_addr2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [15:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk); #1;
        poke_en   = 1'b0;
    endtask

    // Waits (bounded) for ready, then presents w for exactly the accept edge.
    task automatic send(input logic [15:0] w);
        int n = 0;
        while (!inst_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!inst_ready) chk("ready_timeout", 32'(inst_ready), 32'd1);
        inst       = w;
        inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int d0;
        //                inst      addr1  wdata     chk  wr   err  flags
        vecs[0]  = '{16'h8105, 5'd1,  16'h0005, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[1]  = '{16'h82FB, 5'd2,  16'h00FB, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[2]  = '{16'h0102, 5'd1,  16'h0100, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[3]  = '{16'h6304, 5'd3,  16'h7FFF, 1'b1, 1'b0, 1'b0, 4'h8};
        vecs[4]  = '{16'h1505, 5'd5,  16'h0000, 1'b1, 1'b1, 1'b0, 4'h1};
        vecs[5]  = '{16'h9680, 5'd6,  16'hFF80, 1'b1, 1'b1, 1'b0, 4'h4};
        vecs[6]  = '{16'hA123, 5'd1,  16'h0000, 1'b0, 1'b0, 1'b1, 4'h4};
        vecs[7]  = '{16'h0001, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 4'h4};
        vecs[8]  = '{16'h510D, 5'd1,  16'h0000, 1'b0, 1'b0, 1'b1, 4'h4};
        vecs[9]  = '{16'h5701, 5'd7,  16'h0100, 1'b1, 1'b1, 1'b0, 4'h4};
        vecs[10] = '{16'h3201, 5'd2,  16'h01FB, 1'b1, 1'b1, 1'b0, 4'h4};
        vecs[11] = '{16'h2102, 5'd1,  16'h0100, 1'b1, 1'b1, 1'b0, 4'h4};
        vecs[12] = '{16'h4202, 5'd2,  16'h0000, 1'b1, 1'b1, 1'b0, 4'h4};
        vecs[13] = '{16'h8C7F, 5'd12, 16'h007F, 1'b1, 1'b1, 1'b0, 4'h4};
        vecs[14] = '{16'h120C, 5'd2,  16'hFF81, 1'b1, 1'b1, 1'b0, 4'h6};
        vecs[15] = '{16'h0C02, 5'd12, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h3};

        reset      = 1'b1;
        inst       = '0;
        inst_valid = 1'b0;
        rf_clr     = 1'b1;
        poke_en    = 1'b0;
        poke_addr  = '0;
        poke_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(inst_ready), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_write", 32'(reg_write), 32'd0);
        rf_clr = 1'b0;
        reset  = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_ready", 32'(inst_ready), 32'd1);

        poke(5'd3, 16'h8000);
        poke(5'd4, 16'h0001);
        poke(5'd5, 16'h1234);

        for (int i = 0; i < 16; i++) begin
            send(vecs[i].inst);
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("v%0d_write", i), 32'(reg_write), 32'(vecs[i].write));
            chk($sformatf("v%0d_addr1", i), 32'(reg_addr1), 32'(vecs[i].addr1));
            if (vecs[i].chk_wdata)
                chk($sformatf("v%0d_wdata", i), 32'(reg_wdata), 32'(vecs[i].wdata));
            chk($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].flags));
            chk($sformatf("v%0d_ready_in_write", i), 32'(inst_ready), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready_after", i), 32'(inst_ready), 32'd1);
            chk($sformatf("v%0d_done_after", i), 32'(done), 32'd0);
        end
        chk("r1_final", 32'(rf[1]), 32'h0100);
        chk("r7_mov", 32'(rf[7]), 32'h0100);
        chk("r12_add", 32'(rf[12]), 32'h0000);

        // Reset held two cycles while an ADD sits in EXEC.
        send(16'h0102);
        @(posedge clk); #1;
        wr0   = wr_cnt;
        d0    = done_cnt;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_ready_low", 32'(inst_ready), 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        @(posedge clk); #1;
        chk("midrst_ready_high", 32'(inst_ready), 32'd1);
        chk("midrst_no_write", 32'(wr_cnt), 32'(wr0));
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        chk("midrst_r1_kept", 32'(rf[1]), 32'h0100);

        // inst_valid held high with a fresh word every cycle: words 0, 4, 8 are accepted.
        wr0 = wr_cnt;
        d0  = done_cnt;
        for (int i = 0; i < 9; i++) begin
            inst       = 16'h8810 + 16'(i);
            inst_valid = 1'b1;
            @(posedge clk); #1;
        end
        inst_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("hs_r8", 32'(rf[8]), 32'h0018);
        chk("hs_writes", 32'(wr_cnt - wr0), 32'd3);
        chk("hs_dones", 32'(done_cnt - d0), 32'd3);
        chk("hs_flags", 32'(flags), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
